// File: rtl/usb_ep_array.sv
// Multi-endpoint USB controller: per endpoint/direction ping-pong banks, toggle, stall and
// setup state shared between the USB transaction interface and the CPU command/status port.
module usb_ep_array #(
  parameter int unsigned EP_COUNT = 4,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             usb_rst,
  input  logic [3:0]       endpoint,
  input  logic             direction_in,
  input  logic             setup,
  input  logic             success,
  input  logic [CNT_W-1:0] cnt,
  output logic             toggle,
  output logic [1:0]       handshake,
  output logic             bank,
  output logic             in_data_valid,
  output logic [CNT_W-1:0] in_len,
  input  logic [3:0]       ctrl_ep,
  input  logic             ctrl_dir_in,
  input  logic [15:0]      ctrl_wr_data,
  input  logic             ctrl_wr_strobe,
  output logic [15:0]      ctrl_rd_data,
  output logic             irq
);

  localparam int unsigned NEP      = 16;
  localparam logic [1:0]  HS_ACK   = 2'b00;
  localparam logic [1:0]  HS_NAK   = 2'b10;
  localparam logic [1:0]  HS_STALL = 2'b11;

  // Per-endpoint state; the [1:0] packed dimension is the direction (0 = OUT, 1 = IN)
  logic [1:0]       en_q    [NEP], en_d    [NEP];
  logic [1:0]       uptr_q  [NEP], uptr_d  [NEP];
  logic [1:0]       cptr_q  [NEP], cptr_d  [NEP];
  logic [1:0]       tog_q   [NEP], tog_d   [NEP];
  logic [1:0]       stall_q [NEP], stall_d [NEP];
  logic [1:0]       done_q  [NEP], done_d  [NEP];
  logic [1:0]       full_q  [NEP][2], full_d [NEP][2];
  logic [CNT_W-1:0] len_q   [NEP][2][2], len_d [NEP][2][2];
  logic [NEP-1:0]   setf_q, setf_d;

  logic u_ok, c_ok, u_ptr, u_optr, c_ptr, done_any, unused_wr;

  assign u_ok      = {1'b0, endpoint} < 5'(EP_COUNT);
  assign c_ok      = {1'b0, ctrl_ep} < 5'(EP_COUNT);
  assign u_ptr     = uptr_q[endpoint][direction_in];
  assign u_optr    = uptr_q[endpoint][0];
  assign c_ptr     = cptr_q[ctrl_ep][ctrl_dir_in];
  assign unused_wr = ^ctrl_wr_data;

  // Next state: CPU command first, then USB completion so USB sets win over CPU clears
  always_comb begin
    en_d    = en_q;
    uptr_d  = uptr_q;
    cptr_d  = cptr_q;
    tog_d   = tog_q;
    stall_d = stall_q;
    done_d  = done_q;
    full_d  = full_q;
    len_d   = len_q;
    setf_d  = setf_q;

    if (ctrl_wr_strobe && c_ok) begin
      if (ctrl_wr_data[8] && ctrl_dir_in && !full_q[ctrl_ep][1][c_ptr]) begin
        len_d[ctrl_ep][1][c_ptr]  = ctrl_wr_data[CNT_W-1:0];
        full_d[ctrl_ep][1][c_ptr] = 1'b1;
        cptr_d[ctrl_ep][1]        = ~c_ptr;
      end
      if (ctrl_wr_data[9] && !ctrl_dir_in && full_q[ctrl_ep][0][c_ptr]) begin
        full_d[ctrl_ep][0][c_ptr] = 1'b0;
        cptr_d[ctrl_ep][0]        = ~c_ptr;
      end
      if (ctrl_wr_data[10])      stall_d[ctrl_ep][ctrl_dir_in] = 1'b1;
      else if (ctrl_wr_data[11]) stall_d[ctrl_ep][ctrl_dir_in] = 1'b0;
      if (ctrl_wr_data[12]) tog_d[ctrl_ep][ctrl_dir_in] = 1'b0;
      if (ctrl_wr_data[13]) begin
        done_d[ctrl_ep][ctrl_dir_in] = 1'b0;
        if (!ctrl_dir_in) setf_d[ctrl_ep] = 1'b0;
      end
      if (ctrl_wr_data[15]) en_d[ctrl_ep][ctrl_dir_in] = ctrl_wr_data[14];
    end

    if (success && u_ok) begin
      if (setup) begin
        len_d[endpoint][0][u_optr]  = cnt;
        full_d[endpoint][0][u_optr] = 1'b1;
        uptr_d[endpoint][0]         = ~u_optr;
        done_d[endpoint][0]         = 1'b1;
        setf_d[endpoint]            = 1'b1;
        tog_d[endpoint]             = 2'b11;
        stall_d[endpoint]           = 2'b00;
        // Flush queued IN data: the host has restarted the control transfer
        full_d[endpoint][1]         = 2'b00;
        uptr_d[endpoint][1]         = cptr_d[endpoint][1];
      end else if (!direction_in) begin
        len_d[endpoint][0][u_ptr]  = cnt;
        full_d[endpoint][0][u_ptr] = 1'b1;
        uptr_d[endpoint][0]        = ~u_ptr;
        tog_d[endpoint][0]         = ~tog_q[endpoint][0];
        done_d[endpoint][0]        = 1'b1;
      end else begin
        full_d[endpoint][1][u_ptr] = 1'b0;
        uptr_d[endpoint][1]        = ~u_ptr;
        tog_d[endpoint][1]         = ~tog_q[endpoint][1];
        done_d[endpoint][1]        = 1'b1;
      end
    end

    if (usb_rst) begin
      for (int e = 0; e < NEP; e++) begin
        uptr_d[e]  = 2'b00;
        cptr_d[e]  = 2'b00;
        tog_d[e]   = 2'b00;
        stall_d[e] = 2'b00;
        done_d[e]  = 2'b00;
        for (int d = 0; d < 2; d++) begin
          full_d[e][d]   = 2'b00;
          len_d[e][d][0] = '0;
          len_d[e][d][1] = '0;
        end
      end
      setf_d = '0;
    end
  end

  always_comb begin
    done_any = 1'b0;
    for (int e = 0; e < NEP; e++) done_any = done_any | (|done_q[e]);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NEP; e++) begin
        en_q[e]    <= (e == 0) ? 2'b11 : 2'b00;
        uptr_q[e]  <= 2'b00;
        cptr_q[e]  <= 2'b00;
        tog_q[e]   <= 2'b00;
        stall_q[e] <= 2'b00;
        done_q[e]  <= 2'b00;
        for (int d = 0; d < 2; d++) begin
          full_q[e][d]   <= 2'b00;
          len_q[e][d][0] <= '0;
          len_q[e][d][1] <= '0;
        end
      end
      setf_q <= '0;
      irq    <= 1'b0;
    end else begin
      en_q    <= en_d;
      uptr_q  <= uptr_d;
      cptr_q  <= cptr_d;
      tog_q   <= tog_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      full_q  <= full_d;
      len_q   <= len_d;
      setf_q  <= setf_d;
      irq     <= done_any;
    end
  end

  // USB-side decode of the addressed endpoint and direction
  always_comb begin
    handshake = HS_STALL;
    if (u_ok && en_q[endpoint][direction_in]) begin
      if (setup)                                   handshake = HS_ACK;
      else if (stall_q[endpoint][direction_in])    handshake = HS_STALL;
      else if (full_q[endpoint][direction_in][u_ptr])
        handshake = direction_in ? HS_ACK : HS_NAK;
      else
        handshake = direction_in ? HS_NAK : HS_ACK;
    end
    toggle        = u_ok & tog_q[endpoint][direction_in];
    bank          = u_ok & u_ptr;
    in_data_valid = u_ok & direction_in & full_q[endpoint][1][uptr_q[endpoint][1]];
    in_len        = in_data_valid ? len_q[endpoint][1][uptr_q[endpoint][1]] : '0;
  end

  // CPU status word
  always_comb begin
    ctrl_rd_data = 16'h0000;
    if (c_ok) begin
      ctrl_rd_data = {c_ptr,
                      en_q[ctrl_ep][ctrl_dir_in],
                      setf_q[ctrl_ep] & ~ctrl_dir_in,
                      done_q[ctrl_ep][ctrl_dir_in],
                      tog_q[ctrl_ep][ctrl_dir_in],
                      stall_q[ctrl_ep][ctrl_dir_in],
                      full_q[ctrl_ep][ctrl_dir_in][~c_ptr],
                      full_q[ctrl_ep][ctrl_dir_in][c_ptr],
                      1'b0,
                      7'(len_q[ctrl_ep][ctrl_dir_in][c_ptr])};
    end
  end

endmodule

// File: tb/tb_usb_ep_array.sv
// Bench for usb_ep_array: directed vector table for the key scenarios, then random traffic
// checked against a rule-level model of endpoint state.
module tb_usb_ep_array;

  localparam int EPC = 4;
  localparam int CW  = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          usb_rst, direction_in, setup, success, toggle, bank, in_data_valid;
  logic          ctrl_dir_in, ctrl_wr_strobe, irq;
  logic [3:0]    endpoint, ctrl_ep;
  logic [CW-1:0] cnt, in_len;
  logic [1:0]    handshake;
  logic [15:0]   ctrl_wr_data, ctrl_rd_data;

  int checks = 0;
  int errors = 0;

  usb_ep_array #(.EP_COUNT(EPC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .usb_rst(usb_rst), .endpoint(endpoint),
    .direction_in(direction_in), .setup(setup), .success(success), .cnt(cnt),
    .toggle(toggle), .handshake(handshake), .bank(bank), .in_data_valid(in_data_valid),
    .in_len(in_len), .ctrl_ep(ctrl_ep), .ctrl_dir_in(ctrl_dir_in),
    .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_strobe(ctrl_wr_strobe),
    .ctrl_rd_data(ctrl_rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: one record of plain variables per endpoint and direction
  bit          ms_en    [16][2];
  bit          ms_full  [16][2][2];
  int unsigned ms_len   [16][2][2];
  bit          ms_up    [16][2];
  bit          ms_cp    [16][2];
  bit          ms_tog   [16][2];
  bit          ms_stall [16][2];
  bit          ms_done  [16][2];
  bit          ms_setf  [16];
  bit          ms_irq;

  function automatic void m_clear(bit hard);
    for (int e = 0; e < 16; e++) begin
      for (int d = 0; d < 2; d++) begin
        if (hard) ms_en[e][d] = (e == 0);
        ms_full[e][d][0] = 0; ms_full[e][d][1] = 0;
        ms_len[e][d][0]  = 0; ms_len[e][d][1]  = 0;
        ms_up[e][d] = 0; ms_cp[e][d] = 0; ms_tog[e][d] = 0;
        ms_stall[e][d] = 0; ms_done[e][d] = 0;
      end
      ms_setf[e] = 0;
    end
  endfunction

  function automatic void m_step(bit ur, int e, int d, bit s, bit sc, int c,
                                 int ce, int cd, bit [15:0] wd, bit ws);
    bit any;
    int p;
    any = 0;
    for (int i = 0; i < 16; i++) any = any | ms_done[i][0] | ms_done[i][1];
    ms_irq = any;
    if (ws && ce < EPC) begin
      p = int'(ms_cp[ce][cd]);
      if (wd[8] && cd == 1 && !ms_full[ce][1][p]) begin
        ms_len[ce][1][p] = int'(wd[6:0]); ms_full[ce][1][p] = 1; ms_cp[ce][1] = !ms_cp[ce][1];
      end
      if (wd[9] && cd == 0 && ms_full[ce][0][p]) begin
        ms_full[ce][0][p] = 0; ms_cp[ce][0] = !ms_cp[ce][0];
      end
      if (wd[10]) ms_stall[ce][cd] = 1;
      else if (wd[11]) ms_stall[ce][cd] = 0;
      if (wd[12]) ms_tog[ce][cd] = 0;
      if (wd[13]) begin
        ms_done[ce][cd] = 0;
        if (cd == 0) ms_setf[ce] = 0;
      end
      if (wd[15]) ms_en[ce][cd] = wd[14];
    end
    if (sc && e < EPC) begin
      if (s) begin
        p = int'(ms_up[e][0]);
        ms_len[e][0][p] = c; ms_full[e][0][p] = 1; ms_up[e][0] = !ms_up[e][0];
        ms_done[e][0] = 1; ms_setf[e] = 1;
        ms_tog[e][0] = 1; ms_tog[e][1] = 1; ms_stall[e][0] = 0; ms_stall[e][1] = 0;
        ms_full[e][1][0] = 0; ms_full[e][1][1] = 0; ms_up[e][1] = ms_cp[e][1];
      end else begin
        p = int'(ms_up[e][d]);
        if (d == 0) begin ms_len[e][0][p] = c; ms_full[e][0][p] = 1; end
        else ms_full[e][1][p] = 0;
        ms_up[e][d] = !ms_up[e][d]; ms_tog[e][d] = !ms_tog[e][d]; ms_done[e][d] = 1;
      end
    end
    if (ur) m_clear(0);
  endfunction

  function automatic int m_hs(int e, int d, bit s);
    if (e >= EPC || !ms_en[e][d]) return 3;
    if (s) return 0;
    if (ms_stall[e][d]) return 3;
    if (d == 0) return ms_full[e][0][ms_up[e][0]] ? 2 : 0;
    return ms_full[e][1][ms_up[e][1]] ? 0 : 2;
  endfunction

  function automatic int m_rd(int ce, int cd);
    int p;
    if (ce >= EPC) return 0;
    p = int'(ms_cp[ce][cd]);
    return (ms_len[ce][cd][p] & 127) | (int'(ms_full[ce][cd][p]) << 8)
         | (int'(ms_full[ce][cd][1-p]) << 9) | (int'(ms_stall[ce][cd]) << 10)
         | (int'(ms_tog[ce][cd]) << 11) | (int'(ms_done[ce][cd]) << 12)
         | (int'(cd == 0 && ms_setf[ce]) << 13) | (int'(ms_en[ce][cd]) << 14) | (p << 15);
  endfunction

  typedef struct {
    bit ur; int ep; bit dir; bit su; bit sc; int cnt; int ce; bit cd; int wd; bit ws;
    int hs; int tog; int bank; int iv; int il; int rd; int irq;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit ur, int ep, bit dir, bit su, bit sc, int c, int ce, bit cd, int wd,
                     bit ws, int hs, int tg, int bk, int iv, int il, int rd, int iq);
    vec_t v;
    v.ur = ur; v.ep = ep; v.dir = dir; v.su = su; v.sc = sc; v.cnt = c;
    v.ce = ce; v.cd = cd; v.wd = wd; v.ws = ws;
    v.hs = hs; v.tog = tg; v.bank = bk; v.iv = iv; v.il = il; v.rd = rd; v.irq = iq;
    tbl.push_back(v);
  endtask

  task automatic drive(bit ur, int ep, bit dir, bit su, bit sc, int c, int ce, bit cd,
                       int wd, bit ws);
    usb_rst = ur; endpoint = 4'(ep); direction_in = dir; setup = su; success = sc;
    cnt = CW'(c); ctrl_ep = 4'(ce); ctrl_dir_in = cd; ctrl_wr_data = 16'(wd);
    ctrl_wr_strobe = ws;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int hs, int tg, int bk, int iv, int il, int rd, int iq);
    chk({tag, "_handshake"}, int'(handshake), hs);
    chk({tag, "_toggle"}, int'(toggle), tg);
    chk({tag, "_bank"}, int'(bank), bk);
    chk({tag, "_in_data_valid"}, int'(in_data_valid), iv);
    chk({tag, "_in_len"}, int'(in_len), il);
    chk({tag, "_ctrl_rd_data"}, int'(ctrl_rd_data), rd);
    chk({tag, "_irq"}, int'(irq), iq);
  endtask

  initial begin
    int e, ce, hs, il;
    bit d, s, sc, cd, ws, ur;
    bit [15:0] wd;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_clear(1);
    ms_irq = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    //   ur ep dir su sc cnt  ce cd  wd      ws  hs tg bk iv il  rd       irq
    add(0, 0, 1, 0, 0, 0,   1, 0, 'h0000, 0,  2, 0, 0, 0, 0,  'h0000, 0); // reset, EP0 IN nak
    add(0, 1, 0, 0, 0, 0,   0, 0, 'h0000, 0,  3, 0, 0, 0, 0,  'h4000, 0); // EP1 disabled
    add(0, 0, 0, 0, 1, 8,   0, 0, 'h0000, 0,  0, 0, 0, 0, 0,  'h4000, 0); // OUT cnt 8
    add(0, 0, 0, 0, 1, 16,  0, 0, 'h0000, 0,  0, 1, 1, 0, 0,  'h5908, 0); // OUT cnt 16
    add(0, 0, 0, 0, 0, 0,   0, 0, 'h0200, 1,  2, 0, 0, 0, 0,  'h5308, 1); // both full, release
    add(0, 0, 0, 0, 0, 0,   0, 0, 'h2200, 1,  0, 0, 0, 0, 0,  'hD110, 1); // release, clear done
    add(0, 1, 1, 0, 0, 0,   1, 1, 'hC000, 1,  3, 0, 0, 0, 0,  'h0000, 1); // enable EP1 IN
    add(0, 1, 1, 0, 0, 0,   1, 1, 'h0140, 1,  2, 0, 0, 0, 0,  'h4000, 0); // arm len 64
    add(0, 1, 1, 0, 1, 0,   1, 1, 'h0000, 0,  0, 0, 0, 1, 64, 'hC200, 0); // IN sent
    add(0, 1, 1, 0, 0, 0,   0, 0, 'h0400, 1,  2, 1, 1, 0, 0,  'h4008, 0); // stall EP0 OUT
    add(0, 0, 0, 0, 0, 0,   0, 1, 'h0105, 1,  3, 0, 0, 0, 0,  'h4000, 1); // arm EP0 IN len 5
    add(0, 0, 0, 1, 1, 8,   0, 0, 'h0000, 0,  0, 0, 0, 0, 0,  'h4408, 1); // SETUP over stall
    add(0, 0, 1, 0, 0, 0,   0, 0, 'h0000, 0,  2, 1, 1, 0, 0,  'h7908, 1); // IN flushed
    add(0, 0, 0, 0, 0, 0,   0, 1, 'h0000, 0,  0, 1, 1, 0, 0,  'hC800, 1); // EP0 IN status
    add(0, 5, 0, 0, 1, 3,   5, 0, 'h0400, 1,  3, 0, 0, 0, 0,  'h0000, 1); // unimplemented ep
    add(0, 5, 1, 0, 0, 0,   1, 1, 'h0120, 1,  3, 0, 0, 0, 0,  'hD800, 1); // arm bank1 len 32
    add(0, 1, 1, 0, 1, 0,   1, 1, 'h0000, 0,  0, 1, 1, 1, 32, 'h5A40, 1); // send bank1
    add(0, 1, 1, 0, 0, 0,   1, 1, 'h010A, 1,  2, 0, 0, 0, 0,  'h5040, 1); // arm bank0 len 10
    add(0, 1, 1, 0, 1, 0,   1, 1, 'h0114, 1,  0, 0, 0, 1, 10, 'hD220, 1); // arm b1 + send b0
    add(0, 1, 1, 0, 0, 0,   1, 1, 'h0000, 0,  0, 1, 1, 1, 20, 'h5A0A, 1); // merged result
    add(1, 1, 1, 0, 1, 0,   1, 1, 'h0000, 0,  0, 1, 1, 1, 20, 'h5A0A, 1); // usb_rst mid-xfer
    add(0, 1, 1, 0, 0, 0,   1, 1, 'h0000, 0,  2, 0, 0, 0, 0,  'h4000, 1); // cleared, en kept
    add(0, 0, 0, 0, 0, 0,   0, 0, 'h0000, 0,  0, 0, 0, 0, 0,  'h4000, 0); // EP0 OUT ready

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ur, tbl[i].ep, tbl[i].dir, tbl[i].su, tbl[i].sc, tbl[i].cnt,
            tbl[i].ce, tbl[i].cd, tbl[i].wd, tbl[i].ws);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].hs, tbl[i].tog, tbl[i].bank, tbl[i].iv,
              tbl[i].il, tbl[i].rd, tbl[i].irq);
      @(posedge clk);
      m_step(tbl[i].ur, tbl[i].ep, tbl[i].dir, tbl[i].su, tbl[i].sc, tbl[i].cnt,
             tbl[i].ce, tbl[i].cd, 16'(tbl[i].wd), tbl[i].ws);
    end

    // Random traffic; USB completions only when the model would acknowledge
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      e  = int'($urandom_range(0, 5));
      d  = 1'($urandom_range(0, 1));
      s  = (d == 0) && ($urandom_range(0, 7) == 0);
      hs = m_hs(e, d, s);
      sc = ((hs == 0) || (e >= EPC)) && ($urandom_range(0, 2) == 0);
      ce = int'($urandom_range(0, 5));
      cd = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      wd[15] = ($urandom_range(0, 7) == 0);
      ws = ($urandom_range(0, 2) == 0);
      ur = ($urandom_range(0, 63) == 0);
      if (ws && sc && ce == e) begin
        wd = wd & 16'hE3FF;
        if (s) wd = wd & 16'hFCFF;
      end
      drive(ur, e, d, s, sc, int'($urandom_range(0, 127)), ce, cd, int'(wd), ws);
      #1;
      il = (e < EPC && d == 1 && ms_full[e][1][ms_up[e][1]]) ? int'(ms_len[e][1][ms_up[e][1]]) : 0;
      chk_all($sformatf("rnd%0d", n), hs,
              (e < EPC) ? int'(ms_tog[e][d]) : 0,
              (e < EPC) ? int'(ms_up[e][d]) : 0,
              (e < EPC && d == 1) ? int'(ms_full[e][1][ms_up[e][1]]) : 0,
              il, m_rd(ce, cd), int'(ms_irq));
      @(posedge clk);
      m_step(ur, e, d, s, sc, int'(cnt), ce, cd, wd, ws);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
